// File: rtl/iob_pkg.sv
// Shared constants for iob_uart: register offsets, STATUS bit indices, engine state encodings.
`timescale 1ns/1ps
package iob_pkg;

    // Register offsets in word units (i_adr[4:2])
    localparam logic [2:0] IOB_UART_TXDATA = 3'd0;
    localparam logic [2:0] IOB_UART_RXDATA = 3'd1;
    localparam logic [2:0] IOB_UART_STATUS = 3'd2;
    localparam logic [2:0] IOB_UART_DIV    = 3'd3;
    localparam logic [2:0] IOB_UART_IE     = 3'd4;

    localparam int ST_TXFULL  = 0;
    localparam int ST_TXBUSY  = 1;
    localparam int ST_RXVALID = 2;
    localparam int ST_OVERRUN = 3;
    localparam int ST_TXOVF   = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // The half-period midpoint check needs at least 2 clocks per bit.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/iob_uart_fifo.sv
// Synchronous circular-buffer FIFO; one extra pointer bit distinguishes full from empty.
`timescale 1ns/1ps
module iob_uart_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          wdata,
    input  logic                  pop,
    output logic [W-1:0]          rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]        mem [DEPTH];
    logic [DEPTH_LOG2:0] wptr;
    logic [DEPTH_LOG2:0] rptr;
    logic                do_push;
    logic                do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                     (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign count   = wptr - rptr;
    assign rdata   = mem[rptr[DEPTH_LOG2-1:0]];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= wdata;
    end

endmodule

// File: rtl/iob_uart.sv
// Memory-mapped 8N1 UART on the core IO bus. Define IOB_UART_IRQ_EN to add the IE register
// at offset 0x10 and the registered o_irq output.
`timescale 1ns/1ps
module iob_uart
    import iob_pkg::*;
#(
    parameter logic [31:0] BASE         = 32'h1000_0000,
    parameter int          TXDEPTH_LOG2 = 3,
    parameter logic [15:0] DIV_RST      = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ls4iob_val,
    output logic        hs_iob4ls_rdy,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    input  logic [3:0]  i_wen,
    output logic [31:0] o_rdat,
    output logic        o_tx,
    input  logic        i_rx
`ifdef IOB_UART_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    // Handshake: every cycle with hs_ls4iob_val high is one complete request (no backpressure);
    // hs_iob4ls_rdy rises exactly the next cycle with o_rdat, even for undecoded addresses.
    logic        hit;
    logic [2:0]  off;
`ifdef IOB_UART_IRQ_EN
    logic [1:0]  ie;
    assign hit = (i_adr[31:5] == BASE[31:5]);
    assign off = i_adr[4:2];
`else
    assign hit = (i_adr[31:4] == BASE[31:4]);
    assign off = {1'b0, i_adr[3:2]};
`endif

    logic unused_bits;
    assign unused_bits = ^{i_adr[1:0], i_wdat[31:16], i_wen[3:2]};

    logic rd_req, wr_req, tx_push, rx_rd, st_wr, div_wr;
    assign rd_req  = hs_ls4iob_val & hit & (i_wen == 4'b0);
    assign wr_req  = hs_ls4iob_val & hit & (i_wen != 4'b0);
    assign tx_push = wr_req & (off == IOB_UART_TXDATA) & i_wen[0];
    assign rx_rd   = rd_req & (off == IOB_UART_RXDATA);
    assign st_wr   = wr_req & (off == IOB_UART_STATUS) & i_wen[0];
    assign div_wr  = wr_req & (off == IOB_UART_DIV) & (|i_wen[1:0]);

    logic [15:0] div;
    logic [7:0]  rxbyte;
    logic        rxvalid, overrun, txovf;

    logic [7:0]              tx_fdata;
    logic                    tx_full, tx_empty, tx_pop;
    logic [TXDEPTH_LOG2:0]   tx_count;
    tx_state_t               tx_state;
    logic [15:0]             tx_cnt;
    logic [2:0]              tx_bit;
    logic [7:0]              tx_sh;
    logic                    txbusy;

    iob_uart_fifo #(.W(8), .DEPTH_LOG2(TXDEPTH_LOG2)) u_txfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (i_wdat[7:0]),
        .pop   (tx_pop),
        .rdata (tx_fdata),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_pop = (tx_state == TX_IDLE) & ~tx_empty;
    assign txbusy = (tx_state != TX_IDLE);

    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        case (off)
            IOB_UART_TXDATA: rd_mux = {tx_full, 23'b0, 8'(tx_count)};
            IOB_UART_RXDATA: rd_mux = {~rxvalid, 23'b0, rxbyte};
            IOB_UART_STATUS: rd_mux = {27'b0, txovf, overrun, rxvalid, txbusy, tx_full};
            IOB_UART_DIV:    rd_mux = {16'b0, div};
`ifdef IOB_UART_IRQ_EN
            IOB_UART_IE:     rd_mux = {30'b0, ie};
`endif
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_iob4ls_rdy <= 1'b0;
            o_rdat        <= '0;
        end else begin
            hs_iob4ls_rdy <= hs_ls4iob_val;
            o_rdat        <= rd_req ? rd_mux : '0;
        end
    end

    // Engines reload their bit counter from div only at bit boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= DIV_RST;
        end else if (div_wr) begin
            div <= clamp_div({i_wen[1] ? i_wdat[15:8] : div[15:8],
                              i_wen[0] ? i_wdat[7:0]  : div[7:0]});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            o_tx     <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        tx_state <= TX_START;
                        tx_cnt   <= div - 16'd1;
                        tx_sh    <= tx_fdata;
                        o_tx     <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
                    else begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= div - 16'd1;
                        tx_bit   <= '0;
                        o_tx     <= tx_sh[0];
                        tx_sh    <= tx_sh >> 1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
                    else begin
                        tx_cnt <= div - 16'd1;
                        if (tx_bit == 3'd7) begin
                            tx_state <= TX_STOP;
                            o_tx     <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            o_tx   <= tx_sh[0];
                            tx_sh  <= tx_sh >> 1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
                    else tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_load;
    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sh;

    assign rx_s    = rx_sync[1];
    assign rx_load = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_sync <= {rx_sync[0], i_rx};
            rx_prev <= rx_s;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= (div >> 1) - 16'd1;
                    end
                end
                RX_START: begin
                    if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
                    else if (rx_s) rx_state <= RX_IDLE;
                    else begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= div - 16'd1;
                        rx_bit   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
                    else begin
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        rx_cnt <= div - 16'd1;
                        rx_bit <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
                    else rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // A read racing a load consumed the old byte, so it is not an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxbyte  <= '0;
            rxvalid <= 1'b0;
            overrun <= 1'b0;
            txovf   <= 1'b0;
        end else begin
            if (rx_load) begin
                rxbyte  <= rx_sh;
                rxvalid <= 1'b1;
            end else if (rx_rd) begin
                rxvalid <= 1'b0;
            end
            if (rx_load && rxvalid && !rx_rd) overrun <= 1'b1;
            else if (st_wr && i_wdat[ST_OVERRUN]) overrun <= 1'b0;
            if (tx_push && tx_full && !tx_pop) txovf <= 1'b1;
            else if (st_wr && i_wdat[ST_TXOVF]) txovf <= 1'b0;
        end
    end

`ifdef IOB_UART_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie    <= 2'b0;
            o_irq <= 1'b0;
        end else begin
            if (wr_req && (off == IOB_UART_IE) && i_wen[0]) ie <= i_wdat[1:0];
            o_irq <= (rxvalid & ie[0]) | (tx_empty & ie[1]);
        end
    end
`endif

endmodule

// File: tb/tb_iob_uart.sv
// Directed self-checking bench for iob_uart: bus handshake, register map, TX waveform, RX, overflow, reset.
`timescale 1ns/1ps
module tb_iob_uart;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        val;
    logic        rdy;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  wen;
    logic [31:0] rdat;
    logic        tx;
    logic        rx;
`ifdef IOB_UART_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iob_uart #(.BASE(BASE), .TXDEPTH_LOG2(3), .DIV_RST(16'd434)) dut (
        .clk           (clk),
        .rst           (rst),
        .hs_ls4iob_val (val),
        .hs_iob4ls_rdy (rdy),
        .i_adr         (adr),
        .i_wdat        (wdat),
        .i_wen         (wen),
        .o_rdat        (rdat),
        .o_tx          (tx),
        .i_rx          (rx)
`ifdef IOB_UART_IRQ_EN
        ,
        .o_irq         (irq)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       output logic [31:0] rd, output logic rdy_o);
        @(negedge clk);
        val = 1'b1; adr = a; wdat = d; wen = we;
        @(negedge clk);
        rdy_o = rdy; rd = rdat;
        val = 1'b0; adr = '0; wdat = '0; wen = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        y;
        bus(a, 32'h0, 4'h0, r, y);
        check({tag, "_rdy"}, y, 1);
        check(tag, r, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        logic [31:0] r;
        logic        y;
        bus(a, d, we, r, y);
        check({tag, "_rdy"}, y, 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
        rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (div) @(negedge clk);
        end
        rx = stop;
        repeat (div) @(negedge clk);
        rx = 1'b1;
    endtask

    // Samples each serial bit on its first clock after the start bit is seen.
    task automatic tx_decode(input int div, output logic [7:0] b, output logic stop, output logic found);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        found = (n < 300);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = tx;
        end
        repeat (div) @(negedge clk);
        stop = tx;
    endtask

    initial begin
        logic [39:0] cap;
        logic [7:0]  db;
        logic        dstop;
        logic        dfound;
        int          n;

        rst = 1'b1; val = 1'b0; adr = '0; wdat = '0; wen = '0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rdy", rdy, 0);
        check("rst_rdat", rdat, 0);
        check("rst_tx", tx, 1);
        rst = 1'b0;
        @(negedge clk);

        rd_chk("init_txdata", BASE + 32'h0, 32'h0000_0000);
        rd_chk("init_rxdata", BASE + 32'h4, 32'h8000_0000);
        rd_chk("init_status", BASE + 32'h8, 32'h0000_0000);
        rd_chk("init_div",    BASE + 32'hC, 32'h0000_01B2);

        // Undecoded accesses still respond, return 0 and do nothing.
        rd_chk("undec_rd", 32'h2000_0000, 32'h0);
        wr("undec_wr", 32'h2000_0000, 32'h0000_00AA, 4'hF);
        rd_chk("undec_no_push", BASE + 32'h0, 32'h0);
        rd_chk("off10_rd", BASE + 32'h10, 32'h0);

        // Back-to-back reads: STATUS, unmapped BASE+0x20, DIV.
        @(negedge clk);
        val = 1'b1; adr = BASE + 32'h8; wen = 4'h0;
        @(negedge clk);
        check("b2b0_rdy", rdy, 1);
        check("b2b0_rdat", rdat, 32'h0);
        adr = BASE + 32'h20;
        @(negedge clk);
        check("b2b1_rdy", rdy, 1);
        check("b2b1_rdat", rdat, 32'h0);
        adr = BASE + 32'hC;
        @(negedge clk);
        check("b2b2_rdy", rdy, 1);
        check("b2b2_rdat", rdat, 32'h0000_01B2);
        val = 1'b0; adr = '0;
        @(negedge clk);
        check("b2b_idle_rdy", rdy, 0);
        check("b2b_idle_rdat", rdat, 32'h0);

        // DIV clamp and byte enables.
        wr("div_zero", BASE + 32'hC, 32'h0000_0000, 4'b0011);
        rd_chk("div_clamp", BASE + 32'hC, 32'h0000_0002);
        wr("div_lo", BASE + 32'hC, 32'hABCD_1204, 4'b0001);
        rd_chk("div_byte_en", BASE + 32'hC, 32'h0000_0004);

        // 0x55 at div=4: start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 4 clocks.
        wr("tx55", BASE + 32'h0, 32'h0000_0055, 4'b0001);
        n = 0;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tx55_start_seen", (n < 100), 1);
        for (int i = 0; i < 40; i++) begin
            cap[i] = tx;
            @(negedge clk);
        end
        check("tx55_wave", cap, 40'hF0F0F0F0F0);

        // RX at div=8: byte, then a second byte before reading -> overrun.
        wr("div8", BASE + 32'hC, 32'h0000_0008, 4'b0011);
        send_rx(8'hA3, 1'b1, 8);
        repeat (4) @(negedge clk);
        rd_chk("rx1_status", BASE + 32'h8, 32'h0000_0004);
        send_rx(8'h5C, 1'b1, 8);
        repeat (4) @(negedge clk);
        rd_chk("rx2_status", BASE + 32'h8, 32'h0000_000C);
        rd_chk("rx2_data", BASE + 32'h4, 32'h0000_005C);
        rd_chk("rx2_data_again", BASE + 32'h4, 32'h8000_005C);
        rd_chk("rx2_status_after", BASE + 32'h8, 32'h0000_0008);
        wr("clr_ovr", BASE + 32'h8, 32'h0000_0008, 4'b0001);
        rd_chk("ovr_cleared", BASE + 32'h8, 32'h0000_0000);

        // Framing error discards the byte; a clean frame is then received.
        send_rx(8'h3C, 1'b0, 8);
        repeat (20) @(negedge clk);
        rd_chk("frame_err_status", BASE + 32'h8, 32'h0000_0000);
        send_rx(8'hA3, 1'b1, 8);
        repeat (4) @(negedge clk);
        rd_chk("rx3_data", BASE + 32'h4, 32'h0000_00A3);

        // 3-clock glitch at div=16 must not start a frame.
        wr("div16", BASE + 32'hC, 32'h0000_0010, 4'b0011);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rd_chk("glitch_status", BASE + 32'h8, 32'h0000_0000);
        rd_chk("glitch_rxdata", BASE + 32'h4, 32'h8000_00A3);

        // TX stalled at div=1000: starter byte in flight, then 9 pushes overflow an 8-deep FIFO.
        wr("div1000", BASE + 32'hC, 32'h0000_03E8, 4'b0011);
        wr("push_ff", BASE + 32'h0, 32'h0000_00FF, 4'b0001);
        for (int i = 0; i < 9; i++) wr("push_n", BASE + 32'h0, 32'h10 + i, 4'b0001);
        rd_chk("ovf_txdata", BASE + 32'h0, 32'h8000_0008);
        rd_chk("ovf_status", BASE + 32'h8, 32'h0000_0013);
        wr("clr_txovf", BASE + 32'h8, 32'h0000_0010, 4'b0001);
        rd_chk("txovf_cleared", BASE + 32'h8, 32'h0000_0003);

        // Speed up; the starter's remaining bits are all 1, so wait for the line to rise.
        wr("div2", BASE + 32'hC, 32'h0000_0002, 4'b0011);
        n = 0;
        while (tx !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("starter_done", (n < 2000), 1);
        for (int i = 0; i < 8; i++) begin
            tx_decode(2, db, dstop, dfound);
            check("q_found", dfound, 1);
            check("q_byte", db, 8'h10 + 8'(i));
            check("q_stop", dstop, 1);
        end
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        check("no_9th_byte", n, 0);
        rd_chk("drained_txdata", BASE + 32'h0, 32'h0000_0000);
        rd_chk("drained_status", BASE + 32'h8, 32'h0000_0000);

        // Reset mid-frame with 3 bytes queued.
        wr("div1000b", BASE + 32'hC, 32'h0000_03E8, 4'b0011);
        for (int i = 0; i < 4; i++) wr("push_r", BASE + 32'h0, 32'hA1 + i, 4'b0001);
        rd_chk("queued3", BASE + 32'h0, 32'h0000_0003);
        repeat (20) @(negedge clk);
        check("midframe_tx", tx, 0);
        rst = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_chk("post_rst_txdata", BASE + 32'h0, 32'h0000_0000);
        rd_chk("post_rst_div", BASE + 32'hC, 32'h0000_01B2);
        rd_chk("post_rst_status", BASE + 32'h8, 32'h0000_0000);
        n = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) n++;
        end
        check("post_rst_idle", n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_uart.md
Name: iob_uart

Overview:
- IO-bus responder (target) for the core's load/store IO path, i.e. any address with adr[31:16] != 0.
- Accepts one request per cycle on the hs_ls4iob_val handshake and returns hs_iob4ls_rdy plus read data exactly one cycle later.
- Implements a memory-mapped 8N1 UART: TX FIFO, single-entry RX holding register, status register and baud divider.

Parameters:
- BASE, 32'h1000_0000: block base address; decode when i_adr[31:4] == BASE[31:4].
- TXDEPTH_LOG2, 3: TX FIFO depth is 2**TXDEPTH_LOG2 entries.
- DIV_RST, 16'd434: reset baud divider, in clocks per bit.

Ports:
- clk  in  1  core clock, single clock domain.
- rst  in  1  asynchronous reset, active-high.
- hs_ls4iob_val  in  1  request valid, one-cycle pulse per access.
- hs_iob4ls_rdy  out  1  response strobe, cycle after a request.
- i_adr  in  32  byte address.
- i_wdat  in  32  write data.
- i_wen  in  4  byte write enables; 4'b0 means read.
- o_rdat  out  32  read data, valid while hs_iob4ls_rdy is high.
- o_tx  out  1  serial out, idle high.
- i_rx  in  1  serial in, asynchronous.

Behaviour:
- Reset values: hs_iob4ls_rdy=0, o_rdat=0, o_tx=1, FIFO empty, RX invalid, overrun=0, div=DIV_RST.
- Handshake:
  - Every cycle with hs_ls4iob_val=1 is a complete request; there is no backpressure.
  - hs_iob4ls_rdy is the registered value of hs_ls4iob_val.
  - o_rdat is registered in the request cycle and presented the next cycle. It is 0 when there is no request.
  - Back-to-back requests get back-to-back responses.
- Undecoded address or unmapped offset: the response is still given, with o_rdat=0 and no side effect. A bad address must never hang the core.
- Register map (offset = i_adr[3:2]):
  - 0x0 TXDATA
    - Write with i_wen[0] pushes i_wdat[7:0]. A push while full is dropped and sets txovf.
    - Read returns {full, 23'b0, count[7:0]} (count zero-extended).
  - 0x4 RXDATA
    - Read returns {~rxvalid, 23'b0, rxbyte} and clears rxvalid in the same cycle.
    - Writes are ignored.
  - 0x8 STATUS
    - Read returns {27'b0, txovf, overrun, rxvalid, txbusy, txfull}.
    - Write with i_wen[0]: writing 1 to bit3 clears overrun; writing 1 to bit4 clears txovf.
  - 0xC DIV
    - Read/write [15:0], byte-enabled by i_wen[1:0].
    - Writes below 2 clamp to 2.
    - A change takes effect at the next bit boundary.
- TX engine:
  - States IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - Each state lasts div clocks.
  - The FIFO pops on the IDLE->START transition.
  - txbusy = state != IDLE.
- TX FIFO:
  - Circular buffer with TXDEPTH_LOG2+1-bit pointers; full and empty are decided by the MSB compare.
  - A simultaneous push and pop while full succeeds, and the count is unchanged.
- RX engine:
  - 2-flop synchroniser, then IDLE / START / DATA / STOP.
  - A falling edge in IDLE starts the START state. The line is re-checked at div/2; if high it is a glitch and RX returns to IDLE.
  - Data bits are sampled every div clocks from that midpoint.
  - STOP sample high: load rxbyte and set rxvalid. If rxvalid was already 1, set overrun and overwrite rxbyte.
  - STOP sample low (framing error): the byte is discarded and RX returns to IDLE.
- Same-cycle conflicts:
  - RX load vs RXDATA read: the load wins, so rxvalid stays 1. The read returns the old byte and does not flag overrun.
  - RX overrun-set vs STATUS clear: the set wins.
- Reset mid-frame: both engines return to IDLE immediately, o_tx goes to 1, and the FIFO contents are lost.

Optional Feature:
- Macro: IOB_UART_IRQ_EN.
- When defined:
  - Adds output port o_irq, width 1, registered, reset 0.
  - o_irq = (rxvalid & ie[0]) | (txempty & ie[1]).
  - Adds an IE register at offset 0x10 (i_adr[4:2]=3'b100), read/write [1:0], reset 0.
  - Decode widens to i_adr[31:5].
- When undefined: no o_irq port; offset 0x10 reads 0.

Decomposition:
- Shared package iob_pkg holds:
  - Register offset constants (IOB_UART_TXDATA/RXDATA/STATUS/DIV/IE).
  - Status bit index constants.
  - The TX/RX state encodings.
- One natural sub-module: iob_uart_fifo, a parameterised synchronous FIFO reused for TX.
- The RX/TX engines stay inline.

Test Plan:
- Reset: assert rst mid-frame with 3 bytes queued -> o_tx=1, TXDATA reads 0x00000000 at the first access after reset, DIV reads 434.
- Write 0x55 to TXDATA with div=4 -> hs_iob4ls_rdy 1 cycle later; o_tx shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 4 clocks.
- Push 9 bytes with TXDEPTH_LOG2=3 while TX is stalled (div=1000) -> TXDATA reads {1,...,count=8}; STATUS txovf=1; 9th byte never transmitted.
- Drive 0xA3 on i_rx at div=8, then a 2nd byte before reading -> STATUS overrun=1, RXDATA reads 0x000000xx with the 2nd byte, then bit31=1 on the next read.
- Back-to-back reads: STATUS, then unmapped BASE+0x20, then DIV -> rdy on 3 consecutive cycles, data STATUS, 0, 0x000001B2.
- 3-clock low glitch on i_rx at div=16 -> rxvalid stays 0.
